// File: rtl/cache_pkg.sv
// Shared types and tree pseudo-LRU helpers for the set-associative cache storage.
package cache_pkg;

  localparam int unsigned CACHE_INDEX_W = 4;
  localparam int unsigned SETS          = 2 ** CACHE_INDEX_W;

  // Trees are handled at a fixed maximum width (up to 32 ways) and trimmed by callers.
  localparam int unsigned PLRU_MAX_W   = 31;
  localparam int unsigned PLRU_MAX_LVL = 5;

  typedef logic [PLRU_MAX_W-1:0] plru_bits_t;

  typedef enum logic [0:0] {
    IDLE,
    FILL
  } cache_fill_state_t;

  function automatic int unsigned plru_levels(int unsigned ways);
    int unsigned lvls;
    lvls = 0;
    for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
      if ((32'd1 << l) < ways) lvls++;
    end
    return lvls;
  endfunction

  // Heap-ordered tree: node n uses bits[n-1]; a 1 means the right subtree is least recently used.
  function automatic int unsigned plru_victim(plru_bits_t bits, int unsigned ways);
    int unsigned node;
    plru_bits_t  sh;
    node = 1;
    for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
      if (l < plru_levels(ways)) begin
        sh   = bits >> (node - 1);
        node = 2 * node + (sh[0] ? 32'd1 : 32'd0);
      end
    end
    return node - ways;
  endfunction

  function automatic plru_bits_t plru_touch(plru_bits_t bits, int unsigned way, int unsigned ways);
    int unsigned node;
    int unsigned lvls;
    int unsigned dir;
    plru_bits_t  res;
    plru_bits_t  mask;
    res  = bits;
    node = 1;
    lvls = plru_levels(ways);
    for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
      if (l < lvls) begin
        dir  = (way >> (lvls - 1 - l)) & 32'd1;
        mask = plru_bits_t'(1) << (node - 1);
        if (dir != 0) res = res & ~mask;
        else          res = res | mask;
        node = 2 * node + dir;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU state with one touch port and one victim query port.
module cache_plru
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned WAYS    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       touch_en,
  input  logic [INDEX_W-1:0]         touch_index,
  input  logic [$clog2(WAYS)-1:0]    touch_way,
  input  logic [INDEX_W-1:0]         query_index,
  output logic [$clog2(WAYS)-1:0]    victim
);

  localparam int unsigned PlruW   = WAYS - 1;
  localparam int unsigned WayW    = $clog2(WAYS);
  localparam int unsigned NumSets = 2 ** INDEX_W;

  logic [NumSets-1:0][PlruW-1:0] bits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q <= '0;
    end else if (touch_en) begin
      bits_q[touch_index] <= PlruW'(plru_touch(plru_bits_t'(bits_q[touch_index]),
                                               32'(touch_way), WAYS));
    end
  end

  assign victim = WayW'(plru_victim(plru_bits_t'(bits_q[query_index]), WAYS));

endmodule

// File: rtl/cache_sa_storage.sv
// N-way set-associative line storage: registered lookup, dirty tracking, PLRU victim
// selection and a counted refill that exposes the evicted words for writeback.
module cache_sa_storage
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned INDEX_W         = 4,
  parameter int unsigned TAG_W           = 7,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned WAYS            = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [INDEX_W-1:0]              req_index,
  input  logic [TAG_W-1:0]                req_tag,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] req_word,
  input  logic                            req_we,
  input  logic [DATA_W-1:0]               req_wdata,
  output logic                            rsp_valid,
  output logic                            rsp_hit,
  output logic [$clog2(WAYS)-1:0]         rsp_way,
  output logic [DATA_W-1:0]               rsp_rdata,
  input  logic                            fill_start,
  input  logic [INDEX_W-1:0]              fill_index,
  input  logic [TAG_W-1:0]                fill_tag,
  input  logic                            fill_wvalid,
  input  logic [DATA_W-1:0]               fill_wdata,
  output logic                            fill_busy,
  output logic [$clog2(WAYS)-1:0]         victim_way,
  output logic                            victim_valid,
  output logic                            victim_dirty,
  output logic [TAG_W-1:0]                victim_tag,
  output logic [DATA_W-1:0]               victim_rdata,
  output logic                            fill_done
);

  localparam int unsigned WORD_W  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned WAY_W   = $clog2(WAYS);
  localparam int unsigned NumSets = 2 ** INDEX_W;
  localparam int unsigned ADDR_W  = INDEX_W + WAY_W + WORD_W;

  cache_fill_state_t state_q, state_d;

  logic [NumSets-1:0][WAYS-1:0]             valid_q;
  logic [NumSets-1:0][WAYS-1:0]             dirty_q;
  logic [NumSets-1:0][WAYS-1:0][TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0]                        mem_q [2**ADDR_W];

  logic [INDEX_W-1:0] fill_index_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic [WAY_W-1:0]   victim_way_q;
  logic               victim_valid_q;
  logic               victim_dirty_q;
  logic [TAG_W-1:0]   victim_tag_q;
  logic [WORD_W-1:0]  beat_q;
  logic               fill_done_q;

  logic               rsp_valid_q;
  logic               rsp_hit_q;
  logic [WAY_W-1:0]   rsp_way_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic [DATA_W-1:0]  rsp_rdata_d;

  logic               req_accept;
  logic               start;
  logic               beat;
  logic               last_beat;
  logic               wr_hit;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic               inv_found;
  logic [WAY_W-1:0]   inv_way;
  logic [WAY_W-1:0]   plru_way;
  logic [WAY_W-1:0]   sel_way;
  logic [ADDR_W-1:0]  rsp_addr;
  logic [ADDR_W-1:0]  fill_addr;

  assign req_ready  = (state_q == IDLE) && !fill_start;
  assign req_accept = req_valid && req_ready;
  assign start      = (state_q == IDLE) && fill_start;
  assign beat       = (state_q == FILL) && fill_wvalid;
  assign last_beat  = beat && (beat_q == WORD_W'(WORDS_PER_BLOCK - 1));
  assign wr_hit     = req_accept && hit && req_we;
  assign rsp_addr   = {req_index, hit_way, req_word};
  assign fill_addr  = {fill_index_q, victim_way_q, beat_q};

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // An empty way always beats the PLRU choice; the lowest-numbered one wins.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[fill_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    sel_way = inv_found ? inv_way : plru_way;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  cache_plru #(
    .INDEX_W (INDEX_W),
    .WAYS    (WAYS)
  ) u_plru (
    .clk         (clk),
    .rst_n       (rst_n),
    .touch_en    ((req_accept && hit) || last_beat),
    .touch_index ((state_q == FILL) ? fill_index_q : req_index),
    .touch_way   ((state_q == FILL) ? victim_way_q : hit_way),
    .query_index (fill_index),
    .victim      (plru_way)
  );

  // Read happens before the same-edge write, so write hits return the old word.
  assign rsp_rdata_d = hit ? mem_q[rsp_addr] : '0;

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem_q[rsp_addr] <= req_wdata;
    end else if (beat) begin
      mem_q[fill_addr] <= fill_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      tag_q          <= '0;
      fill_index_q   <= '0;
      fill_tag_q     <= '0;
      victim_way_q   <= '0;
      victim_valid_q <= 1'b0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
      beat_q         <= '0;
      fill_done_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_hit_q      <= 1'b0;
      rsp_way_q      <= '0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      fill_done_q <= last_beat;
      rsp_valid_q <= req_accept;
      rsp_hit_q   <= req_accept && hit;
      rsp_way_q   <= (req_accept && hit) ? hit_way : '0;
      rsp_rdata_q <= req_accept ? rsp_rdata_d : '0;

      if (start) begin
        fill_index_q   <= fill_index;
        fill_tag_q     <= fill_tag;
        victim_way_q   <= sel_way;
        victim_valid_q <= valid_q[fill_index][sel_way];
        victim_dirty_q <= dirty_q[fill_index][sel_way];
        victim_tag_q   <= tag_q[fill_index][sel_way];
        beat_q         <= '0;
      end else if (beat) begin
        beat_q <= beat_q + WORD_W'(1);
      end

      if (wr_hit) dirty_q[req_index][hit_way] <= 1'b1;

      if (last_beat) begin
        tag_q[fill_index_q][victim_way_q]   <= fill_tag_q;
        valid_q[fill_index_q][victim_way_q] <= 1'b1;
        dirty_q[fill_index_q][victim_way_q] <= 1'b0;
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_hit      = rsp_hit_q;
  assign rsp_way      = rsp_way_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign fill_busy    = (state_q == FILL);
  assign fill_done    = fill_done_q;
  assign victim_way   = victim_way_q;
  assign victim_valid = victim_valid_q;
  assign victim_dirty = victim_dirty_q;
  assign victim_tag   = victim_tag_q;
  assign victim_rdata = fill_busy ? mem_q[fill_addr] : '0;

endmodule
